// File: rtl/alu_flag_commit_stage_pkg.sv
// Shared ALU definitions: flag indices, packed flag type and skid-buffer states.
// Imported by the commit stage and by the flag-producing ALU blocks.
package alu_flag_commit_stage_pkg;

    localparam int unsigned FLAG_W = 5;

    localparam int unsigned CF = 0;
    localparam int unsigned ZF = 1;
    localparam int unsigned OF = 2;
    localparam int unsigned PF = 3;
    localparam int unsigned SF = 4;

    typedef struct packed {
        logic sf;
        logic pf;
        logic of;
        logic zf;
        logic cf;
    } alu_flags_t;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_MAIN  = 2'd1,
        SKID_FULL  = 2'd2
    } skid_state_e;

    // Bits set in mask take the new value; the rest keep the current value.
    function automatic alu_flags_t merge_flags(input alu_flags_t cur,
                                               input alu_flags_t upd,
                                               input alu_flags_t mask);
        return alu_flags_t'((upd & mask) | (cur & ~mask));
    endfunction

endpackage

// File: rtl/alu_skid_buffer.sv
// Generic 2-entry valid/ready register (main + skid), strictly FIFO.
// ready_o and valid_o decode directly from the state register.
module alu_skid_buffer
    import alu_flag_commit_stage_pkg::*;
#(
    parameter int unsigned DATA_W = 20
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [DATA_W-1:0] data_o
);

    skid_state_e       state_q, state_d;
    logic [DATA_W-1:0] main_q, skid_q;
    logic              accept, consume;
    logic              load_main_in, load_main_skid, load_skid_in;

    assign accept  = valid_i && ready_o;
    assign consume = valid_o && ready_i;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= SKID_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            if (load_main_in)
                main_q <= data_i;
            else if (load_main_skid)
                main_q <= skid_q;
            if (load_skid_in)
                skid_q <= data_i;
        end
    end

    always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid_in   = 1'b0;
        unique case (state_q)
            SKID_EMPTY: begin
                if (accept) begin
                    state_d      = SKID_MAIN;
                    load_main_in = 1'b1;
                end
            end
            SKID_MAIN: begin
                if (accept && consume) begin
                    load_main_in = 1'b1;
                end else if (accept) begin
                    state_d      = SKID_FULL;
                    load_skid_in = 1'b1;
                end else if (consume) begin
                    state_d = SKID_EMPTY;
                end
            end
            SKID_FULL: begin
                // ready_o is low here, so only the skid-to-main move can occur.
                if (consume) begin
                    state_d        = SKID_MAIN;
                    load_main_skid = 1'b1;
                end
            end
            default: state_d = SKID_EMPTY;
        endcase
    end

    always_comb begin
        valid_o = (state_q != SKID_EMPTY);
        ready_o = (state_q != SKID_FULL);
        data_o  = main_q;
    end

endmodule

// File: rtl/alu_flag_commit_stage.sv
// ALU commit stage: buffers {tag,result} through a skid buffer and holds the
// architectural flags register, updated at input handshake under fmask_i.
module alu_flag_commit_stage
    import alu_flag_commit_stage_pkg::*;
#(
    parameter int unsigned WORD_WIDTH = 16,
    parameter int unsigned TAG_WIDTH  = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [WORD_WIDTH-1:0] r_i,
    input  logic [TAG_WIDTH-1:0]  tag_i,
    input  logic [FLAG_W-1:0]     flags_i,
    input  logic [FLAG_W-1:0]     fmask_i,
    input  logic                  flags_we_i,
    input  logic [FLAG_W-1:0]     flags_wdata_i,
    output logic [FLAG_W-1:0]     flags_o,
    output logic                  cf_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [WORD_WIDTH-1:0] r_o,
    output logic [TAG_WIDTH-1:0]  tag_o
);

    localparam int unsigned DATA_W = TAG_WIDTH + WORD_WIDTH;

    logic [DATA_W-1:0] buf_din, buf_dout;
    alu_flags_t        flags_q;
    logic              accept;

    assign buf_din = {tag_i, r_i};
    assign {tag_o, r_o} = buf_dout;

    alu_skid_buffer #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .data_i  (buf_din),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .data_o  (buf_dout)
    );

    assign accept = valid_i && ready_o;

    // Flags commit at acceptance, independent of downstream stalls, so the
    // carry fed back to the ALU is current for the next issued operation.
    always_ff @(posedge clk_i) begin
        if (!rst_ni)
            flags_q <= '0;
        else if (flags_we_i)
            flags_q <= alu_flags_t'(flags_wdata_i);
        else if (accept)
            flags_q <= merge_flags(flags_q, alu_flags_t'(flags_i), alu_flags_t'(fmask_i));
    end

    assign flags_o = flags_q;
    assign cf_o    = flags_q.cf;

endmodule

// File: tb/tb_alu_flag_commit_stage.sv
// Directed self-checking bench for alu_flag_commit_stage.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_alu_flag_commit_stage;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        valid_i;
    logic        ready_o;
    logic [15:0] r_i;
    logic [3:0]  tag_i;
    logic [4:0]  flags_i;
    logic [4:0]  fmask_i;
    logic        flags_we_i;
    logic [4:0]  flags_wdata_i;
    logic [4:0]  flags_o;
    logic        cf_o;
    logic        valid_o;
    logic        ready_i;
    logic [15:0] r_o;
    logic [3:0]  tag_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    alu_flag_commit_stage #(
        .WORD_WIDTH (16),
        .TAG_WIDTH  (4)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .valid_i       (valid_i),
        .ready_o       (ready_o),
        .r_i           (r_i),
        .tag_i         (tag_i),
        .flags_i       (flags_i),
        .fmask_i       (fmask_i),
        .flags_we_i    (flags_we_i),
        .flags_wdata_i (flags_wdata_i),
        .flags_o       (flags_o),
        .cf_o          (cf_o),
        .valid_o       (valid_o),
        .ready_i       (ready_i),
        .r_o           (r_o),
        .tag_o         (tag_o)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] r, input logic [3:0] t,
                         input logic [4:0] f, input logic [4:0] m);
        valid_i = v;
        r_i     = r;
        tag_i   = t;
        flags_i = f;
        fmask_i = m;
    endtask

    task automatic single_transfer(input string pfx);
        ready_i = 1'b1;
        drive(1'b1, 16'h8001, 4'd3, 5'b10001, 5'b11111);
        tick();
        drive(1'b0, 16'h0000, 4'd0, 5'b00000, 5'b00000);
        check_eq({pfx, "_valid"}, valid_o, 1);
        check_eq({pfx, "_r"},     r_o, 16'h8001);
        check_eq({pfx, "_tag"},   tag_o, 3);
        check_eq({pfx, "_flags"}, flags_o, 5'b10001);
        check_eq({pfx, "_cf"},    cf_o, 1);
        tick();
        check_eq({pfx, "_drain"}, valid_o, 0);
    endtask

    initial begin
        // Reset held two cycles with a valid input pending
        rst_ni        = 1'b0;
        ready_i       = 1'b0;
        flags_we_i    = 1'b0;
        flags_wdata_i = 5'b00000;
        drive(1'b1, 16'hDEAD, 4'd9, 5'b11111, 5'b11111);
        tick();
        tick();
        check_eq("rst_valid", valid_o, 0);
        check_eq("rst_ready", ready_o, 1);
        check_eq("rst_flags", flags_o, 0);
        check_eq("rst_r",     r_o, 0);
        check_eq("rst_tag",   tag_o, 0);
        rst_ni = 1'b1;
        drive(1'b0, 16'h0000, 4'd0, 5'b00000, 5'b00000);
        tick();
        check_eq("post_rst_valid", valid_o, 0);
        check_eq("post_rst_flags", flags_o, 0);

        single_transfer("single");

        // Masked update: set flags to 00001 first, then update only pf/of
        flags_we_i    = 1'b1;
        flags_wdata_i = 5'b00001;
        tick();
        flags_we_i    = 1'b0;
        check_eq("we_preset", flags_o, 5'b00001);
        drive(1'b1, 16'h1234, 4'd5, 5'b00110, 5'b00110);
        tick();
        drive(1'b0, 16'h0000, 4'd0, 5'b00000, 5'b00000);
        check_eq("mask_flags", flags_o, 5'b00111);
        check_eq("mask_cf",    cf_o, 1);
        check_eq("mask_r",     r_o, 16'h1234);
        tick();
        check_eq("mask_drain", valid_o, 0);

        // Backpressure: A, B fill both entries; C is held; flags of B commit while stalled
        ready_i = 1'b0;
        drive(1'b1, 16'h0001, 4'd1, 5'b00000, 5'b00000);
        tick();
        check_eq("bp_a_ready", ready_o, 1);
        check_eq("bp_a_r",     r_o, 16'h0001);
        drive(1'b1, 16'h0002, 4'd2, 5'b10100, 5'b11111);
        tick();
        check_eq("bp_full_ready", ready_o, 0);
        check_eq("bp_stall_flags", flags_o, 5'b10100);
        drive(1'b1, 16'h0003, 4'd3, 5'b01011, 5'b11111);
        tick();
        tick();
        check_eq("bp_held_ready", ready_o, 0);
        check_eq("bp_held_r",     r_o, 16'h0001);
        check_eq("bp_held_flags", flags_o, 5'b10100);
        ready_i = 1'b1;
        tick();
        check_eq("bp_out_b_r",     r_o, 16'h0002);
        check_eq("bp_out_b_tag",   tag_o, 2);
        check_eq("bp_out_b_ready", ready_o, 1);
        check_eq("bp_out_b_valid", valid_o, 1);
        tick();
        drive(1'b0, 16'h0000, 4'd0, 5'b00000, 5'b00000);
        check_eq("bp_out_c_r",     r_o, 16'h0003);
        check_eq("bp_out_c_tag",   tag_o, 3);
        check_eq("bp_c_flags",     flags_o, 5'b01011);
        tick();
        check_eq("bp_drain", valid_o, 0);

        // Direct write overrides a same-cycle handshake update
        drive(1'b1, 16'hBEEF, 4'd7, 5'b11111, 5'b11111);
        flags_we_i    = 1'b1;
        flags_wdata_i = 5'b01010;
        tick();
        flags_we_i = 1'b0;
        drive(1'b0, 16'h0000, 4'd0, 5'b00000, 5'b00000);
        check_eq("wp_flags", flags_o, 5'b01010);
        check_eq("wp_cf",    cf_o, 0);
        check_eq("wp_valid", valid_o, 1);
        check_eq("wp_r",     r_o, 16'hBEEF);
        check_eq("wp_tag",   tag_o, 7);
        tick();
        check_eq("wp_drain", valid_o, 0);

        // Reset with both entries full
        ready_i = 1'b0;
        drive(1'b1, 16'h0011, 4'd1, 5'b11111, 5'b11111);
        tick();
        drive(1'b1, 16'h0022, 4'd2, 5'b11111, 5'b11111);
        tick();
        check_eq("mr_full_ready", ready_o, 0);
        rst_ni = 1'b0;
        drive(1'b0, 16'h0000, 4'd0, 5'b00000, 5'b00000);
        tick();
        rst_ni = 1'b1;
        check_eq("mr_valid", valid_o, 0);
        check_eq("mr_ready", ready_o, 1);
        check_eq("mr_flags", flags_o, 0);
        check_eq("mr_r",     r_o, 0);
        single_transfer("mr_single");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_flag_commit_stage.md
Name: alu_flag_commit_stage

Overview:
- Downstream stage of the ALU operation blocks (shift, arithmetic, logic).
- Registers each ALU result with its flag outputs behind a valid/ready handshake, using a 2-entry skid buffer.
- Holds the architectural flags register under a per-operation update mask.
- Feeds the registered carry back to the ALU blocks' carry-in, so a dependent operation issued next cycle sees the updated carry.

Parameters:
- WORD_WIDTH, 16, width of ALU result word.
- TAG_WIDTH, 4, width of destination-register tag carried alongside the result.

Ports:
- clk_i  input  1  clock, all logic on rising edge.
- rst_ni  input  1  reset: synchronous, active-low.
- valid_i  input  1  upstream result valid.
- ready_o  output  1  stage can accept; registered.
- r_i  input  WORD_WIDTH  ALU result.
- tag_i  input  TAG_WIDTH  destination tag.
- flags_i  input  5  ALU flags, bit order {sf,pf,of,zf,cf} (bit0=cf).
- fmask_i  input  5  per-bit flag update enable, same order.
- flags_we_i  input  1  direct flags-register write (control path).
- flags_wdata_i  input  5  direct write data.
- flags_o  output  5  architectural flags register.
- cf_o  output  1  equals flags_o[0]; drives ALU carry-in.
- valid_o  output  1  result available downstream.
- ready_i  input  1  downstream accepts.
- r_o  output  WORD_WIDTH  committed result.
- tag_o  output  TAG_WIDTH  committed tag.

Behaviour:
- Reset (rst_ni=0 at posedge):
  - Both buffer entries invalidated.
  - valid_o=0, ready_o=1 on the following cycle.
  - r_o=0, tag_o=0, flags_o=0.
  - Reset mid-transfer discards all buffered entries; no partial commit.
- Handshakes:
  - Input accepted when valid_i && ready_o.
  - Output consumed when valid_o && ready_i.
  - Upstream holds r_i/tag_i/flags_i/fmask_i stable while valid_i && !ready_o.
- Buffer:
  - Two entries: main (drives outputs) and skid.
  - Accepted data goes to main if main is empty or being consumed this cycle; otherwise to skid.
  - When main is consumed and skid is valid, skid moves to main on the same edge.
  - Order is strictly FIFO.
- Latency: 1 cycle from input handshake to valid_o when the buffer is empty.
- Throughput: 1 per cycle while ready_i=1.
- ready_o:
  - Registered; ready_o = !skid_valid.
  - When both entries are full, ready_o=0 the next cycle; no accept is lost.
  - Accept and consume in the same cycle with main valid and skid empty: occupancy is unchanged and ready_o stays 1.
- Flags register:
  - Updated at the input handshake, not at output, so cf_o reflects operation N by the cycle after N is accepted.
  - Per bit i: flags_o[i] <= fmask_i[i] ? flags_i[i] : flags_o[i].
  - flags_we_i=1 loads flags_wdata_i into all 5 bits and overrides a same-cycle handshake update entirely.
  - Flags are not stored per entry; r_o/tag_o carry only data.
- Stall: a stall (ready_i=0) never blocks flag updates of accepted entries.
- Width rules: no arithmetic; widths pass through unchanged.

Decomposition:
- Shared ALU package contains:
  - Flag index constants: CF=0, ZF=1, OF=2, PF=3, SF=4.
  - FLAG_W=5.
  - Packed flags typedef alu_flags_t with fields sf,pf,of,zf,cf.
- The existing flag-producing blocks adopt the same package.
- One natural sub-module: alu_skid_buffer.
  - Generic 2-entry valid/ready register parameterised by data width.
  - Carries {tag,result}.
- The flags register stays in the top module.

Test Plan:
- Reset: hold rst_ni=0 two cycles with valid_i=1 -> after release valid_o=0, ready_o=1, flags_o=5'b00000, no accept during reset.
- Single transfer: r_i=16'h8001, tag_i=3, flags_i=5'b10001, fmask_i=5'b11111, ready_i=1 -> next cycle valid_o=1, r_o=16'h8001, tag_o=3, flags_o=5'b10001, cf_o=1; one cycle later valid_o=0.
- Masked update: flags_o=5'b00001, input flags_i=5'b00110, fmask_i=5'b00110 -> flags_o=5'b00111; cf retained.
- Backpressure: ready_i=0, push A=16'h0001, B=16'h0002 back-to-back -> ready_o=0 after B, third push C=16'h0003 held; raise ready_i -> outputs A, B, C in order on consecutive cycles, none dropped or duplicated.
- Write priority: same cycle as handshake with flags_i=5'b11111, fmask_i=5'b11111, assert flags_we_i=1, flags_wdata_i=5'b01010 -> flags_o=5'b01010; result still enters buffer.
- Mid-operation reset: both entries full, ready_i=0, assert rst_ni=0 one cycle -> valid_o=0, ready_o=1, flags_o=0 next cycle; subsequent transfer behaves as the single-transfer scenario.
